// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: FIFO geometry, entry layout
// and the per-cycle FIFO operation encoding.
package uart_pkg;

    localparam int UART_FIFO_DEPTH    = 16;
    localparam int UART_FIFO_ADDR_W   = $clog2(UART_FIFO_DEPTH);
    localparam int UART_FIFO_ENTRY_W  = 9;
    localparam int PERR_BIT           = 8;
    localparam int DATA_MSB           = 7;
    localparam int UART_TIMEOUT_TICKS = 640;

    // Encoded as {write_accepted, read_accepted}
    typedef enum logic [1:0] {
        FIFO_OP_NONE  = 2'b00,
        FIFO_OP_RD    = 2'b01,
        FIFO_OP_WR    = 2'b10,
        FIFO_OP_WR_RD = 2'b11
    } fifo_op_e;

    function automatic logic [UART_FIFO_ENTRY_W-1:0] pack_entry(
        input logic                perr,
        input logic [DATA_MSB:0]   data
    );
        return {perr, data};
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage for the UART receive FIFO: DEPTH x WIDTH register array with one
// synchronous write port and one combinational read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WIDTH  = UART_FIFO_ENTRY_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers and
    // level, so clearing storage would only cost flops and a reset fan-out.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver with level, overrun,
// threshold and flush. Define UART_RX_FIFO_TIMEOUT_EN to build the stale-data timeout.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH         = UART_FIFO_DEPTH,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int TIMEOUT_TICKS = UART_TIMEOUT_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rx_done,
    input  logic [7:0]        i_rx_data,
    input  logic              i_parity_err,
    input  logic              i_rx_tick,
    input  logic              i_rd_en,
    input  logic              i_flush,
    input  logic              i_clr_overrun,
    input  logic [ADDR_W:0]   i_thresh,
    output logic [7:0]        o_rd_data,
    output logic              o_rd_perr,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR_W:0]   o_level,
    output logic              o_overrun,
    output logic              o_thresh_irq,
    output logic              o_timeout
);

    localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W + 1)'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q,  level_d;
    logic              overrun_q, overrun_d;

    logic              empty;
    logic              full;
    logic              wr_accept;
    logic              rd_accept;
    logic              overrun_set;
    fifo_op_e          op;
    logic [UART_FIFO_ENTRY_W-1:0] head_entry;

    assign empty = (level_q == '0);
    assign full  = (level_q == LEVEL_FULL);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write
    // paired with a read. Flush discards both sides of the cycle.
    assign wr_accept   = i_rx_done && (!full || i_rd_en) && !i_flush;
    assign rd_accept   = i_rd_en && !empty && !i_flush;
    assign overrun_set = i_rx_done && full && !i_rd_en && !i_flush;
    assign op          = fifo_op_e'({wr_accept, rd_accept});

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (UART_FIFO_ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (wr_accept),
        .i_waddr (wr_ptr_q),
        .i_wdata (pack_entry(i_parity_err, i_rx_data)),
        .i_raddr (rd_ptr_q),
        .o_rdata (head_entry)
    );

    always_comb begin
        // NOTE: every signal driven here gets its hold value first, so no path
        // through the case/if leaves it unassigned and infers a latch.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;

        unique case (op)
            FIFO_OP_WR: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                level_d  = level_q + LEVEL_ONE;
            end
            FIFO_OP_RD: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                level_d  = level_q - LEVEL_ONE;
            end
            FIFO_OP_WR_RD: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            default: ;
        endcase

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        // Set is evaluated last so a drop wins over a same-cycle clear
        if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    // The array holds stale data when empty, so the head is masked to zero
    always_comb begin
        o_rd_data = '0;
        o_rd_perr = 1'b0;
        if (!empty) begin
            o_rd_data = head_entry[DATA_MSB:0];
            o_rd_perr = head_entry[PERR_BIT];
        end
    end

    assign o_empty      = empty;
    assign o_full       = full;
    assign o_level      = level_q;
    assign o_overrun    = overrun_q;
    assign o_thresh_irq = (i_thresh != '0) && (level_q >= i_thresh);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int              TMO_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_TICKS);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Any FIFO activity means the host is not stalled, so the age restarts
    always_comb begin
        tmo_d = tmo_q;
        if (empty || wr_accept || rd_accept || i_flush) begin
            tmo_d = '0;
        end else if (i_rx_tick && (tmo_q != TMO_MAX)) begin
            tmo_d = tmo_q + TMO_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign o_timeout = (tmo_q >= TMO_MAX);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = i_rx_tick ^ (TIMEOUT_TICKS == 0);
    assign o_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, full/overrun, flush, threshold,
// asynchronous reset and the optional timeout (UART_RX_FIFO_TIMEOUT_EN).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic       i_parity_err;
    logic       i_rx_tick;
    logic       i_rd_en;
    logic       i_flush;
    logic       i_clr_overrun;
    logic [4:0] i_thresh;
    logic [7:0] o_rd_data;
    logic       o_rd_perr;
    logic       o_empty;
    logic       o_full;
    logic [4:0] o_level;
    logic       o_overrun;
    logic       o_thresh_irq;
    logic       o_timeout;

    int n_chk = 0;
    int n_bad = 0;

    uart_rx_fifo dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_done     (i_rx_done),
        .i_rx_data     (i_rx_data),
        .i_parity_err  (i_parity_err),
        .i_rx_tick     (i_rx_tick),
        .i_rd_en       (i_rd_en),
        .i_flush       (i_flush),
        .i_clr_overrun (i_clr_overrun),
        .i_thresh      (i_thresh),
        .o_rd_data     (o_rd_data),
        .o_rd_perr     (o_rd_perr),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_level       (o_level),
        .o_overrun     (o_overrun),
        .o_thresh_irq  (o_thresh_irq),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // One clock with the given strobes; outputs are sampled 1 ns after the edge
    task automatic cyc(input logic done, input logic [7:0] data, input logic perr,
                       input logic rd, input logic flush, input logic clr);
        i_rx_done     = done;
        i_rx_data     = data;
        i_parity_err  = perr;
        i_rd_en       = rd;
        i_flush       = flush;
        i_clr_overrun = clr;
        @(posedge clk);
        #1;
        i_rx_done     = 1'b0;
        i_rx_data     = 8'h00;
        i_parity_err  = 1'b0;
        i_rd_en       = 1'b0;
        i_flush       = 1'b0;
        i_clr_overrun = 1'b0;
    endtask

    task automatic wr(input logic [7:0] data, input logic perr);
        cyc(1'b1, data, perr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        i_rx_done     = 1'b0;
        i_rx_data     = 8'h00;
        i_parity_err  = 1'b0;
        i_rx_tick     = 1'b0;
        i_rd_en       = 1'b0;
        i_flush       = 1'b0;
        i_clr_overrun = 1'b0;
        i_thresh      = 5'd0;
        #12;
        check("rst_empty",   o_empty,   1);
        check("rst_full",    o_full,    0);
        check("rst_level",   o_level,   0);
        check("rst_overrun", o_overrun, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_data",    o_rd_data, 0);
        check("rst_perr",    o_rd_perr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic ordering with parity flag
        wr(8'hA5, 1'b0);
        wr(8'h3C, 1'b1);
        check("two_level", o_level, 2);
        check("two_head",  o_rd_data, 8'hA5);
        check("two_perr",  o_rd_perr, 0);
        pop();
        check("pop1_head", o_rd_data, 8'h3C);
        check("pop1_perr", o_rd_perr, 1);
        pop();
        check("pop2_empty", o_empty, 1);
        check("pop2_data",  o_rd_data, 0);
        pop();
        check("pop_empty_level", o_level, 0);
        check("pop_empty_flag",  o_empty, 1);

        // Fill to full, then one more write overruns
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
        check("fill_level",   o_level, 16);
        check("fill_full",    o_full, 1);
        check("fill_overrun", o_overrun, 0);
        wr(8'h10, 1'b0);
        check("ovr_flag",  o_overrun, 1);
        check("ovr_level", o_level, 16);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_overrun", o_overrun, 0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
        check("set_beats_clr", o_overrun, 1);
        check("set_clr_level", o_level, 16);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_again", o_overrun, 0);
        check("full_head", o_rd_data, 8'h00);

        // Write plus read at full: both happen, no overrun
        cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wr_rd_full_level",   o_level, 16);
        check("wr_rd_full_overrun", o_overrun, 0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_%0d", i), o_rd_data, 32'(i));
            pop();
        end
        check("drain_last", o_rd_data, 8'h55);
        pop();
        check("drain_empty", o_empty, 1);

        // Write plus read on empty: write only
        cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        check("empty_wr_rd_level", o_level, 1);
        check("empty_wr_rd_head",  o_rd_data, 8'h77);

        // Threshold
        i_thresh = 5'd4;
        #1;
        check("thr_lvl1", o_thresh_irq, 0);
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        check("thr_lvl3", o_thresh_irq, 0);
        wr(8'h03, 1'b0);
        check("thr_lvl4", o_thresh_irq, 1);
        pop();
        check("thr_pop",  o_thresh_irq, 0);
        wr(8'h04, 1'b0);
        wr(8'h05, 1'b0);
        check("lvl5", o_level, 5);
        check("thr_lvl5", o_thresh_irq, 1);
        i_thresh = 5'd0;
        #1;
        check("thr_disabled", o_thresh_irq, 0);

        // Flush overrides a concurrent write and read
        cyc(1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_level",   o_level, 0);
        check("flush_empty",   o_empty, 1);
        check("flush_overrun", o_overrun, 0);
        check("flush_data",    o_rd_data, 0);
        wr(8'h99, 1'b1);
        check("post_flush_head", o_rd_data, 8'h99);
        check("post_flush_perr", o_rd_perr, 1);
        pop();

        // Flush leaves a sticky overrun in place
        for (int i = 0; i < 17; i++) wr(8'(i), 1'b0);
        check("ovr2_flag", o_overrun, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("flush_keeps_ovr", o_overrun, 1);
        check("flush2_level", o_level, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ovr2", o_overrun, 0);

        // Asynchronous reset mid-cycle
        wr(8'h42, 1'b0);
        wr(8'h43, 1'b0);
        check("pre_rst_level", o_level, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_level", o_level, 0);
        check("async_rst_empty", o_empty, 1);
        check("async_rst_data",  o_rd_data, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stale-data timeout
        wr(8'hAB, 1'b0);
        i_rx_tick = 1'b1;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        repeat (639) @(posedge clk);
        #1;
        check("tmo_639", o_timeout, 0);
        @(posedge clk);
        #1;
        check("tmo_640", o_timeout, 1);
        repeat (5) @(posedge clk);
        #1;
        check("tmo_sat", o_timeout, 1);
        i_rx_tick = 1'b0;
        pop();
        check("tmo_pop", o_timeout, 0);
`else
        repeat (700) @(posedge clk);
        #1;
        check("tmo_off", o_timeout, 0);
        i_rx_tick = 1'b0;
        pop();
        check("tmo_off_pop", o_timeout, 0);
`endif
        check("tmo_end_empty", o_empty, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
